// File: rtl/reflet_vga_txt_writer_if.sv
// Byte-stream input and text-buffer write port of the terminal-style text writer.
// The host side (master) supplies characters and colours; the writer (slave) drives the write port.
interface reflet_vga_txt_writer_if #(
    parameter int color_depth = 8,
    parameter int h_w         = 7,
    parameter int v_w         = 6
);
    logic [7:0]             char_in;
    logic                   char_valid;
    logic                   char_ready;
    logic                   set_color;
    logic [color_depth-1:0] R_fg_in, G_fg_in, B_fg_in;
    logic [color_depth-1:0] R_bg_in, G_bg_in, B_bg_in;
    logic                   write_en;
    logic [h_w-1:0]         h_txt_out;
    logic [v_w-1:0]         v_txt_out;
    logic [7:0]             char_out;
    logic [color_depth-1:0] R_fg_out, G_fg_out, B_fg_out;
    logic [color_depth-1:0] R_bg_out, G_bg_out, B_bg_out;
    logic [h_w-1:0]         cursor_h;
    logic [v_w-1:0]         cursor_v;

    modport master (
        output char_in, char_valid, set_color,
        output R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
        input  char_ready, write_en, h_txt_out, v_txt_out, char_out,
        input  R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
        input  cursor_h, cursor_v
    );

    modport slave (
        input  char_in, char_valid, set_color,
        input  R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
        output char_ready, write_en, h_txt_out, v_txt_out, char_out,
        output R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
        output cursor_h, cursor_v
    );
endinterface

// File: rtl/reflet_vga_txt_writer.sv
// Terminal front end for the VGA text buffer: cursor tracking, control codes and
// line/screen blanking, emitting one registered text-buffer write per cycle.
module reflet_vga_txt_writer #(
    parameter int h_size         = 640,
    parameter int v_size         = 480,
    parameter int color_depth    = 8,
    parameter int bit_reduction  = 0,
    parameter bit clear_line     = 1'b1,
    parameter bit clear_on_reset = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reflet_vga_txt_writer_if.slave   bus
);
    localparam int COLS = h_size / 8 / (2 ** bit_reduction);
    localparam int ROWS = v_size / 8 / (2 ** bit_reduction);
    localparam int HW   = $clog2(h_size / 8) - bit_reduction;
    localparam int VW   = $clog2(v_size / 8) - bit_reduction;
    localparam logic [HW-1:0] COL_LAST = HW'(COLS - 1);
    localparam logic [VW-1:0] ROW_LAST = VW'(ROWS - 1);
    localparam logic [7:0]    SPACE    = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

    state_t         state_reg;
    logic           ready_reg, write_en_reg;
    logic [HW-1:0]  h_out_reg, cur_h_reg, clr_h_reg;
    logic [VW-1:0]  v_out_reg, cur_v_reg, clr_v_reg;
    logic [7:0]     char_out_reg;

    // Colour registers, one per channel: fg resets to all ones, bg to all zeros.
    logic [color_depth-1:0] color_in [6];
    assign color_in = '{bus.R_fg_in, bus.G_fg_in, bus.B_fg_in,
                        bus.R_bg_in, bus.G_bg_in, bus.B_bg_in};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_color
            localparam logic [color_depth-1:0] RST_VAL =
                (gi < 3) ? {color_depth{1'b1}} : {color_depth{1'b0}};
            logic [color_depth-1:0] val_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    val_reg <= RST_VAL;
                else if (bus.set_color)
                    val_reg <= color_in[gi];
            end
        end
    endgenerate

    // Decode of the byte offered this cycle, evaluated against the current cursor.
    logic           accept, acc_write, advance, start_screen, start_line;
    logic [HW-1:0]  next_h, acc_wh;
    logic [VW-1:0]  next_v, acc_wv, v_inc;
    logic [7:0]     acc_char;
    logic [HW:0]    tab_h;

    assign accept = bus.char_valid && ready_reg;
    assign v_inc  = (cur_v_reg == ROW_LAST) ? '0 : cur_v_reg + VW'(1);
    assign tab_h  = ({1'b0, cur_h_reg} | (HW+1)'(7)) + (HW+1)'(1);

    always_comb begin
        acc_write    = 1'b0;
        acc_wh       = cur_h_reg;
        acc_wv       = cur_v_reg;
        acc_char     = bus.char_in;
        next_h       = cur_h_reg;
        next_v       = cur_v_reg;
        advance      = 1'b0;
        start_screen = 1'b0;
        if (bus.char_in >= 8'h20 && bus.char_in != 8'h7F) begin
            acc_write = 1'b1;
            if (cur_h_reg == COL_LAST) begin
                next_h  = '0;
                advance = 1'b1;
            end else begin
                next_h = cur_h_reg + HW'(1);
            end
        end else begin
            case (bus.char_in)
                8'h0A: begin next_h = '0; advance = 1'b1; end
                8'h0D: next_h = '0;
                8'h09: begin
                    if (tab_h >= (HW+1)'(COLS)) begin
                        next_h  = '0;
                        advance = 1'b1;
                    end else begin
                        next_h = tab_h[HW-1:0];
                    end
                end
                8'h08: begin
                    acc_char = SPACE;
                    if (cur_h_reg != '0) begin
                        next_h    = cur_h_reg - HW'(1);
                        acc_wh    = cur_h_reg - HW'(1);
                        acc_write = 1'b1;
                    end else if (cur_v_reg != '0) begin
                        next_h    = COL_LAST;
                        next_v    = cur_v_reg - VW'(1);
                        acc_wh    = COL_LAST;
                        acc_wv    = cur_v_reg - VW'(1);
                        acc_write = 1'b1;
                    end
                end
                8'h0C: begin
                    start_screen = 1'b1;
                    next_h       = '0;
                    next_v       = '0;
                end
                default: ;
            endcase
        end
        if (advance)
            next_v = v_inc;
    end
    assign start_line = advance && clear_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= clear_on_reset ? CLR_SCREEN : IDLE;
            ready_reg    <= !clear_on_reset;
            write_en_reg <= 1'b0;
            h_out_reg    <= '0;
            v_out_reg    <= '0;
            char_out_reg <= SPACE;
            cur_h_reg    <= '0;
            cur_v_reg    <= '0;
            clr_h_reg    <= '0;
            clr_v_reg    <= '0;
        end else begin
            write_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        cur_h_reg <= next_h;
                        cur_v_reg <= next_v;
                        if (acc_write) begin
                            write_en_reg <= 1'b1;
                            h_out_reg    <= acc_wh;
                            v_out_reg    <= acc_wv;
                            char_out_reg <= acc_char;
                        end
                        // A clear with no character write emits its first blank immediately.
                        if (start_screen) begin
                            state_reg    <= CLR_SCREEN;
                            ready_reg    <= 1'b0;
                            write_en_reg <= 1'b1;
                            h_out_reg    <= '0;
                            v_out_reg    <= '0;
                            char_out_reg <= SPACE;
                            clr_h_reg    <= HW'(1);
                            clr_v_reg    <= '0;
                        end else if (start_line) begin
                            state_reg <= CLR_LINE;
                            ready_reg <= 1'b0;
                            clr_v_reg <= next_v;
                            if (acc_write) begin
                                clr_h_reg <= '0;
                            end else begin
                                write_en_reg <= 1'b1;
                                h_out_reg    <= '0;
                                v_out_reg    <= next_v;
                                char_out_reg <= SPACE;
                                clr_h_reg    <= HW'(1);
                            end
                        end
                    end
                end
                CLR_LINE: begin
                    ready_reg    <= 1'b0;
                    write_en_reg <= 1'b1;
                    h_out_reg    <= clr_h_reg;
                    v_out_reg    <= clr_v_reg;
                    char_out_reg <= SPACE;
                    if (clr_h_reg == COL_LAST)
                        state_reg <= IDLE;
                    else
                        clr_h_reg <= clr_h_reg + HW'(1);
                end
                CLR_SCREEN: begin
                    ready_reg    <= 1'b0;
                    write_en_reg <= 1'b1;
                    h_out_reg    <= clr_h_reg;
                    v_out_reg    <= clr_v_reg;
                    char_out_reg <= SPACE;
                    if (clr_h_reg == COL_LAST) begin
                        clr_h_reg <= '0;
                        if (clr_v_reg == ROW_LAST)
                            state_reg <= IDLE;
                        else
                            clr_v_reg <= clr_v_reg + VW'(1);
                    end else begin
                        clr_h_reg <= clr_h_reg + HW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.char_ready = ready_reg;
    assign bus.write_en   = write_en_reg;
    assign bus.h_txt_out  = h_out_reg;
    assign bus.v_txt_out  = v_out_reg;
    assign bus.char_out   = char_out_reg;
    assign bus.cursor_h   = cur_h_reg;
    assign bus.cursor_v   = cur_v_reg;
    assign bus.R_fg_out   = g_color[0].val_reg;
    assign bus.G_fg_out   = g_color[1].val_reg;
    assign bus.B_fg_out   = g_color[2].val_reg;
    assign bus.R_bg_out   = g_color[3].val_reg;
    assign bus.G_bg_out   = g_color[4].val_reg;
    assign bus.B_bg_out   = g_color[5].val_reg;
endmodule

// File: tb/tb_reflet_vga_txt_writer.sv
// Bench for the text writer: a screen-level model expands every accepted byte into the
// ordered list of writes it must produce; every cycle the DUT outputs are compared to it.
module tb_reflet_vga_txt_writer;
    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reflet_vga_txt_writer_if #(.color_depth(8), .h_w(7), .v_w(6)) bus ();

    reflet_vga_txt_writer #(
        .h_size(640), .v_size(480), .color_depth(8), .bit_reduction(0),
        .clear_line(1'b1), .clear_on_reset(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int h;
        int v;
        int ch;
        bit clr;
    } wr_t;

    wr_t        q[$];
    wr_t        disp;
    bit         disp_v;
    bit         m_ready;
    bit         last_acc;
    int         m_h, m_v;
    logic [7:0] m_col [6];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic void push(int h, int v, int ch, bit clr);
        wr_t w;
        w.h = h; w.v = v; w.ch = ch; w.clr = clr;
        q.push_back(w);
    endfunction

    function automatic void advance_row();
        m_v = (m_v + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push(c, m_v, 32, 1'b1);
    endfunction

    function automatic void push_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push(c, r, 32, 1'b1);
    endfunction

    function automatic void model_reset();
        q.delete();
        disp_v  = 1'b0;
        m_h     = 0;
        m_v     = 0;
        m_ready = 1'b0;
        m_col   = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        push_screen();
    endfunction

    // Effect of one rising edge, given the inputs currently driven.
    function automatic void model_edge();
        int c;
        bit acc;
        c   = int'(bus.char_in);
        acc = bus.char_valid && m_ready;
        last_acc = acc;
        if (bus.set_color)
            m_col = '{bus.R_fg_in, bus.G_fg_in, bus.B_fg_in, bus.R_bg_in, bus.G_bg_in, bus.B_bg_in};
        if (acc) begin
            if (c >= 32 && c != 127) begin
                push(m_h, m_v, c, 1'b0);
                m_h++;
                if (m_h == COLS) begin m_h = 0; advance_row(); end
            end else if (c == 10) begin
                m_h = 0; advance_row();
            end else if (c == 13) begin
                m_h = 0;
            end else if (c == 9) begin
                m_h = (m_h | 7) + 1;
                if (m_h >= COLS) begin m_h = 0; advance_row(); end
            end else if (c == 8) begin
                if (m_h > 0) begin
                    m_h--; push(m_h, m_v, 32, 1'b0);
                end else if (m_v > 0) begin
                    m_v--; m_h = COLS - 1; push(m_h, m_v, 32, 1'b0);
                end
            end else if (c == 12) begin
                m_h = 0; m_v = 0; push_screen();
            end
        end
        disp_v = (q.size() > 0);
        if (disp_v) disp = q.pop_front();
        m_ready = !(disp_v && disp.clr) && (q.size() == 0);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("write_en", 64'(bus.write_en), 64'(disp_v));
        if (disp_v) begin
            chk("h_txt_out", 64'(bus.h_txt_out), 64'(disp.h));
            chk("v_txt_out", 64'(bus.v_txt_out), 64'(disp.v));
            chk("char_out", 64'(bus.char_out), 64'(disp.ch));
        end
        chk("char_ready", 64'(bus.char_ready), 64'(m_ready));
        chk("cursor_h", 64'(bus.cursor_h), 64'(m_h));
        chk("cursor_v", 64'(bus.cursor_v), 64'(m_v));
        chk("colours", 64'({bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out}),
            64'({m_col[0], m_col[1], m_col[2], m_col[3], m_col[4], m_col[5]}));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 6000);
        if (!last_acc) begin
            n_bad++;
            $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", c, n);
        end
        bus.char_valid = 1'b0;
    endtask

    task automatic drain(output int nw);
        int n;
        n  = 0;
        nw = 0;
        while (!m_ready && n < 20000) begin
            tick();
            nw += int'(bus.write_en);
            n++;
        end
        if (!m_ready) begin
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic chk_write(string name, int h, int v, int ch);
        chk({name, " we"}, 64'(bus.write_en), 64'(1));
        chk({name, " h"}, 64'(bus.h_txt_out), 64'(h));
        chk({name, " v"}, 64'(bus.v_txt_out), 64'(v));
        chk({name, " ch"}, 64'(bus.char_out), 64'(ch));
    endtask

    task automatic chk_cursor(string name, int h, int v);
        chk({name, " cursor_h"}, 64'(bus.cursor_h), 64'(h));
        chk({name, " cursor_v"}, 64'(bus.cursor_v), 64'(v));
    endtask

    initial begin
        int nw;
        logic [7:0] s1 [6];
        logic [7:0] s2 [7];
        s1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        s2 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        bus.char_in = 8'h00; bus.char_valid = 1'b0; bus.set_color = 1'b0;
        bus.R_fg_in = 8'h00; bus.G_fg_in = 8'h00; bus.B_fg_in = 8'h00;
        bus.R_bg_in = 8'h00; bus.G_bg_in = 8'h00; bus.B_bg_in = 8'h00;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst write_en", 64'(bus.write_en), 64'(0));
        chk("rst char_out", 64'(bus.char_out), 64'h20);
        chk("rst h_txt_out", 64'(bus.h_txt_out), 64'(0));
        chk("rst v_txt_out", 64'(bus.v_txt_out), 64'(0));
        chk("rst char_ready", 64'(bus.char_ready), 64'(0));
        chk("rst fg/bg", 64'({bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out}),
            64'h0000_FFFFFF_000000);
        compare();
        rst_n = 1'b1;
        drain(nw);
        chk("reset clear writes", 64'(nw), 64'(4800));

        // Back-to-back printables
        send(8'h41);
        chk_write("A", 0, 0, 8'h41);
        send(8'h42);
        chk_write("B", 1, 0, 8'h42);
        chk_cursor("AB", 2, 0);

        // TAB at h=3, then TAB wrapping from h=78
        send(8'h43);
        send(8'h09);
        chk("tab3 write_en", 64'(bus.write_en), 64'(0));
        chk_cursor("tab3", 8, 0);
        repeat (8) send(8'h09);
        foreach (s1[i]) send(s1[i]);
        chk_cursor("h78", 78, 0);
        send(8'h09);
        chk_cursor("tab78", 0, 1);
        chk_write("tab78 clear", 0, 1, 8'h20);

        // BS at column 0 moves to the end of the previous row
        repeat (4) send(8'h0A);
        chk_cursor("lf x4", 0, 5);
        send(8'h08);
        chk_write("bs(0,5)", 79, 4, 8'h20);
        chk_cursor("bs(0,5)", 79, 4);

        // Printable at (79,59) wraps to row 0 and blanks it; next byte waits
        repeat (55) send(8'h0A);
        repeat (9) send(8'h09);
        foreach (s2[i]) send(s2[i]);
        chk_cursor("h79 v59", 79, 59);
        send(8'h5A);
        chk_write("Z", 79, 59, 8'h5A);
        chk_cursor("Z", 0, 0);
        send(8'h51);
        chk_write("Q after clear", 0, 0, 8'h51);

        // BS at (0,0), ignored codes, high printable
        send(8'h0D);
        send(8'h08);
        chk("bs(0,0) write_en", 64'(bus.write_en), 64'(0));
        chk_cursor("bs(0,0)", 0, 0);
        send(8'h01);
        send(8'h7F);
        chk("ignored write_en", 64'(bus.write_en), 64'(0));
        send(8'h80);
        chk_write("0x80", 0, 0, 8'h80);
        send(8'h0D);

        // set_color on the same edge as an accepted byte
        bus.set_color = 1'b1;
        bus.R_fg_in = 8'h12; bus.G_fg_in = 8'h34; bus.B_fg_in = 8'h56;
        bus.R_bg_in = 8'h9A; bus.G_bg_in = 8'hBC; bus.B_bg_in = 8'hDE;
        send(8'h78);
        bus.set_color = 1'b0;
        chk_write("x newcolour", 0, 0, 8'h78);
        chk("x colours", 64'({bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out}),
            64'h0000_123456_9ABCDE);

        // FF, colour change mid-clear, then reset mid-clear
        send(8'h0C);
        chk_write("FF first", 0, 0, 8'h20);
        repeat (50) tick();
        bus.set_color = 1'b1;
        bus.R_fg_in = 8'h01; bus.G_fg_in = 8'h02; bus.B_fg_in = 8'h03;
        bus.R_bg_in = 8'h04; bus.G_bg_in = 8'h05; bus.B_bg_in = 8'h06;
        tick();
        bus.set_color = 1'b0;
        repeat (50) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset write_en", 64'(bus.write_en), 64'(0));
        chk("async reset ready", 64'(bus.char_ready), 64'(0));
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        drain(nw);
        chk("restart clear writes", 64'(nw), 64'(4800));
        send(8'h41);
        chk_write("A after restart", 0, 0, 8'h41);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
